// File: rtl/proj3_swbtn_axi_slave.sv
// proj3_swbtn_axi_slave
// AXI4-Lite slave exposing board switches, buttons, a latched button-edge
// register with write-one-to-clear semantics, and an LED/interrupt control word.
// Register map (word addressed by addr[3:2]):
//   0x0 SW (RO)   0x4 BTN (RO)   0x8 BTN_EDGE (W1C)   0xC LED_CTRL (RW, bit 31 = irq enable)
// Each channel pair is handled by a small two-process FSM. At most one write
// and one read are in flight at any time.

module proj3_swbtn_axi_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int N_SW               = 8,
  parameter int N_BTN              = 5
) (
  input  logic                              clock,
  input  logic                              reset,
  // write address channel
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s_axi_awaddr,
  input  logic [2:0]                        s_axi_awprot,
  input  logic                              s_axi_awvalid,
  output logic                              s_axi_awready,
  // write data channel
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     s_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s_axi_wstrb,
  input  logic                              s_axi_wvalid,
  output logic                              s_axi_wready,
  // write response channel
  output logic [1:0]                        s_axi_bresp,
  output logic                              s_axi_bvalid,
  input  logic                              s_axi_bready,
  // read address channel
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s_axi_araddr,
  input  logic [2:0]                        s_axi_arprot,
  input  logic                              s_axi_arvalid,
  output logic                              s_axi_arready,
  // read data channel
  output logic [C_S_AXI_DATA_WIDTH-1:0]     s_axi_rdata,
  output logic [1:0]                        s_axi_rresp,
  output logic                              s_axi_rvalid,
  input  logic                              s_axi_rready,
  // board I/O
  input  logic [N_SW-1:0]                   sw,
  input  logic [N_BTN-1:0]                  btn,
  output logic [N_SW-1:0]                   led,
  output logic                              irq
);

  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int NB = C_S_AXI_DATA_WIDTH / 8;

  localparam logic [1:0] SEL_SW   = 2'd0;
  localparam logic [1:0] SEL_BTN  = 2'd1;
  localparam logic [1:0] SEL_EDGE = 2'd2;
  localparam logic [1:0] SEL_LED  = 2'd3;

  typedef enum logic [1:0] {
    WR_IDLE   = 2'b00,
    WR_ACCEPT = 2'b01,
    WR_RESP   = 2'b10
  } wr_state_t;

  typedef enum logic [1:0] {
    RD_IDLE = 2'b00,
    RD_ADDR = 2'b01,
    RD_DATA = 2'b10
  } rd_state_t;

  // FSM state and registered handshake outputs
  wr_state_t          wr_state_q, wr_state_d;
  rd_state_t          rd_state_q, rd_state_d;
  logic               wr_ack_q,   wr_ack_d;
  logic               bvalid_q,   bvalid_d;
  logic               arready_q,  arready_d;
  logic               rvalid_q,   rvalid_d;
  logic [DW-1:0]      rdata_q,    rdata_d;

  // synchronizers and edge detection
  logic [N_SW-1:0]    sw_meta_q,  sw_sync_q;
  logic [N_BTN-1:0]   btn_meta_q, btn_sync_q, btn_prev_q;

  // architectural registers
  logic [N_BTN-1:0]   btn_edge_q, btn_edge_d;
  logic [DW-1:0]      led_ctrl_q, led_ctrl_d;
  logic               irq_q,      irq_d;

  // combinational helpers
  logic [DW-1:0]      strb_mask_s;
  logic [N_BTN-1:0]   edge_clr_s;
  logic [N_BTN-1:0]   btn_rise_s;
  logic [1:0]         wr_sel_s;
  logic [DW-1:0]      sw_ext_s, btn_ext_s, edge_ext_s, rd_mux_s;
  logic               unused_s;

  // Protection bits and the byte offset within a word carry no meaning here.
  assign unused_s = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr, s_axi_araddr};

  assign wr_sel_s = s_axi_awaddr[3:2];

  // Outputs come straight from flops.
  assign s_axi_awready = wr_ack_q;
  assign s_axi_wready  = wr_ack_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = 2'b00;
  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rresp   = 2'b00;
  assign s_axi_rdata   = rdata_q;
  assign led           = led_ctrl_q[N_SW-1:0];
  assign irq           = irq_q;

  // Expand the per-byte write strobes into a per-bit mask.
  always_comb begin
    strb_mask_s = {DW{1'b0}};
    for (int b = 0; b < NB; b++) begin
      strb_mask_s[8*b +: 8] = {8{s_axi_wstrb[b]}};
    end
  end

  // Write channel: AW and W are only taken together, then a single response is held until bready.
  always_comb begin
    wr_state_d = wr_state_q;
    wr_ack_d   = 1'b0;
    bvalid_d   = 1'b0;
    case (wr_state_q)
      WR_IDLE: begin
        if (s_axi_awvalid && s_axi_wvalid) begin
          wr_state_d = WR_ACCEPT;
          wr_ack_d   = 1'b1;
        end else begin
          wr_state_d = WR_IDLE;
        end
      end
      WR_ACCEPT: begin
        wr_state_d = WR_RESP;
        bvalid_d   = 1'b1;
      end
      WR_RESP: begin
        if (s_axi_bready) begin
          wr_state_d = WR_IDLE;
        end else begin
          wr_state_d = WR_RESP;
          bvalid_d   = 1'b1;
        end
      end
      default: begin
        wr_state_d = WR_IDLE;
      end
    endcase
  end

  // Zero-extend the narrow status vectors to bus width.
  always_comb begin
    sw_ext_s               = {DW{1'b0}};
    btn_ext_s              = {DW{1'b0}};
    edge_ext_s             = {DW{1'b0}};
    sw_ext_s[N_SW-1:0]     = sw_sync_q;
    btn_ext_s[N_BTN-1:0]   = btn_sync_q;
    edge_ext_s[N_BTN-1:0]  = btn_edge_q;
  end

  // Read data mux; it sees pre-write register values, so a same-cycle write is not visible.
  always_comb begin
    rd_mux_s = {DW{1'b0}};
    case (s_axi_araddr[3:2])
      SEL_SW:   rd_mux_s = sw_ext_s;
      SEL_BTN:  rd_mux_s = btn_ext_s;
      SEL_EDGE: rd_mux_s = edge_ext_s;
      SEL_LED:  rd_mux_s = led_ctrl_q;
      default:  rd_mux_s = {DW{1'b0}};
    endcase
  end

  // Read channel: one-cycle arready, then hold rvalid/rdata until rready; rdata is zero while idle.
  always_comb begin
    rd_state_d = rd_state_q;
    arready_d  = 1'b0;
    rvalid_d   = 1'b0;
    rdata_d    = {DW{1'b0}};
    case (rd_state_q)
      RD_IDLE: begin
        if (s_axi_arvalid) begin
          rd_state_d = RD_ADDR;
          arready_d  = 1'b1;
        end else begin
          rd_state_d = RD_IDLE;
        end
      end
      RD_ADDR: begin
        rd_state_d = RD_DATA;
        rvalid_d   = 1'b1;
        rdata_d    = rd_mux_s;
      end
      RD_DATA: begin
        if (s_axi_rready) begin
          rd_state_d = RD_IDLE;
        end else begin
          rd_state_d = RD_DATA;
          rvalid_d   = 1'b1;
          rdata_d    = rdata_q;
        end
      end
      default: begin
        rd_state_d = RD_IDLE;
      end
    endcase
  end

  // Register updates: LED_CTRL byte-lane writes, BTN_EDGE set/clear (set wins), irq level.
  always_comb begin
    led_ctrl_d = led_ctrl_q;
    edge_clr_s = {N_BTN{1'b0}};
    if (wr_ack_q) begin
      case (wr_sel_s)
        SEL_EDGE: edge_clr_s = s_axi_wdata[N_BTN-1:0] & strb_mask_s[N_BTN-1:0];
        SEL_LED:  led_ctrl_d = (led_ctrl_q & ~strb_mask_s) | (s_axi_wdata & strb_mask_s);
        default:  led_ctrl_d = led_ctrl_q;  // SW and BTN are read-only
      endcase
    end else begin
      led_ctrl_d = led_ctrl_q;
    end
    btn_rise_s = btn_sync_q & ~btn_prev_q;
    btn_edge_d = (btn_edge_q & ~edge_clr_s) | btn_rise_s;
    irq_d      = led_ctrl_q[DW-1] & (|btn_edge_q);
  end

  // Bus-side state: both FSMs and their registered handshake/data outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_state_q <= WR_IDLE;
      rd_state_q <= RD_IDLE;
      wr_ack_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= {DW{1'b0}};
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
      wr_ack_q   <= wr_ack_d;
      bvalid_q   <= bvalid_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
    end
  end

  // Two-flop synchronizers for the pins plus a third button flop for rising-edge detection.
  always_ff @(posedge clock) begin
    if (reset) begin
      sw_meta_q  <= {N_SW{1'b0}};
      sw_sync_q  <= {N_SW{1'b0}};
      btn_meta_q <= {N_BTN{1'b0}};
      btn_sync_q <= {N_BTN{1'b0}};
      btn_prev_q <= {N_BTN{1'b0}};
    end else begin
      sw_meta_q  <= sw;
      sw_sync_q  <= sw_meta_q;
      btn_meta_q <= btn;
      btn_sync_q <= btn_meta_q;
      btn_prev_q <= btn_sync_q;
    end
  end

  // Architectural registers and the registered interrupt.
  always_ff @(posedge clock) begin
    if (reset) begin
      btn_edge_q <= {N_BTN{1'b0}};
      led_ctrl_q <= {DW{1'b0}};
      irq_q      <= 1'b0;
    end else begin
      btn_edge_q <= btn_edge_d;
      led_ctrl_q <= led_ctrl_d;
      irq_q      <= irq_d;
    end
  end

endmodule

// File: tb/tb_proj3_swbtn_axi_slave.sv
// Directed bench for proj3_swbtn_axi_slave: AXI4-Lite handshakes, register
// map behaviour, button edge/irq path and reset abandonment.

module tb_proj3_swbtn_axi_slave;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  s_axi_awaddr;
  logic [2:0]  s_axi_awprot;
  logic        s_axi_awvalid;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_wvalid;
  logic        s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready;
  logic [3:0]  s_axi_araddr;
  logic [2:0]  s_axi_arprot;
  logic        s_axi_arvalid;
  logic        s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rvalid;
  logic        s_axi_rready;
  logic [7:0]  sw;
  logic [4:0]  btn;
  logic [7:0]  led;
  logic        irq;

  int n_cmp = 0;
  int n_bad = 0;

  proj3_swbtn_axi_slave #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(4),
    .N_SW(8),
    .N_BTN(5)
  ) dut (
    .clock(clock), .reset(reset),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arprot(s_axi_arprot),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .sw(sw), .btn(btn), .led(led), .irq(irq)
  );

  // free-running clock, 10 ns period
  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // advance one clock and settle just past the edge
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input string tag);
    int guard;
    guard         = 0;
    s_axi_awaddr  = addr;
    s_axi_wdata   = data;
    s_axi_wstrb   = strb;
    s_axi_awvalid = 1'b1;
    s_axi_wvalid  = 1'b1;
    do begin
      tick();
      guard++;
    end while (!s_axi_awready && guard < 20);
    check_val({tag, "_awready"}, {31'd0, s_axi_awready}, 32'd1);
    check_val({tag, "_wready"},  {31'd0, s_axi_wready},  32'd1);
    tick();
    s_axi_awvalid = 1'b0;
    s_axi_wvalid  = 1'b0;
    check_val({tag, "_bvalid"}, {31'd0, s_axi_bvalid}, 32'd1);
    check_val({tag, "_bresp"},  {30'd0, s_axi_bresp},  32'd0);
    s_axi_bready = 1'b1;
    tick();
    s_axi_bready = 1'b0;
    check_val({tag, "_bvalid_drop"}, {31'd0, s_axi_bvalid}, 32'd0);
  endtask

  task automatic axi_read(input logic [3:0] addr, input logic [31:0] exp, input string tag);
    int guard;
    guard         = 0;
    s_axi_araddr  = addr;
    s_axi_arvalid = 1'b1;
    do begin
      tick();
      guard++;
    end while (!s_axi_arready && guard < 20);
    check_val({tag, "_arready"}, {31'd0, s_axi_arready}, 32'd1);
    tick();
    s_axi_arvalid = 1'b0;
    check_val({tag, "_rvalid"}, {31'd0, s_axi_rvalid}, 32'd1);
    check_val({tag, "_rresp"},  {30'd0, s_axi_rresp},  32'd0);
    check_val({tag, "_rdata"},  s_axi_rdata, exp);
    s_axi_rready = 1'b1;
    tick();
    s_axi_rready = 1'b0;
    check_val({tag, "_rvalid_drop"}, {31'd0, s_axi_rvalid}, 32'd0);
    check_val({tag, "_rdata_idle"},  s_axi_rdata, 32'd0);
  endtask

  initial begin
    int guard;
    reset         = 1'b1;
    s_axi_awaddr  = 4'h0;
    s_axi_awprot  = 3'd0;
    s_axi_awvalid = 1'b0;
    s_axi_wdata   = 32'd0;
    s_axi_wstrb   = 4'h0;
    s_axi_wvalid  = 1'b0;
    s_axi_bready  = 1'b0;
    s_axi_araddr  = 4'h0;
    s_axi_arprot  = 3'd0;
    s_axi_arvalid = 1'b0;
    s_axi_rready  = 1'b0;
    sw            = 8'h00;
    btn           = 5'h00;

    // reset state
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check_val("rst_awready", {31'd0, s_axi_awready}, 32'd0);
    check_val("rst_bvalid",  {31'd0, s_axi_bvalid},  32'd0);
    check_val("rst_arready", {31'd0, s_axi_arready}, 32'd0);
    check_val("rst_rvalid",  {31'd0, s_axi_rvalid},  32'd0);
    check_val("rst_rdata",   s_axi_rdata,            32'd0);
    check_val("rst_led",     {24'd0, led},           32'd0);
    check_val("rst_irq",     {31'd0, irq},           32'd0);

    // full-word LED_CTRL write and readback; enable set but no edges -> irq low
    axi_write(4'hC, 32'h8000_00A5, 4'hF, "wr_led");
    check_val("led_a5", {24'd0, led}, 32'h0000_00A5);
    axi_read(4'hC, 32'h8000_00A5, "rd_led");
    check_val("irq_no_edge", {31'd0, irq}, 32'd0);

    // byte-lane write: only lane 0 lands
    axi_write(4'hC, 32'h0000_0000, 4'hF, "wr_led_zero");
    axi_write(4'hC, 32'h0000_1234, 4'h1, "wr_led_lane0");
    axi_read(4'hC, 32'h0000_0034, "rd_led_lane0");
    check_val("led_34", {24'd0, led}, 32'h0000_0034);

    // switches through the synchronizer; writes to RO registers ignored
    sw = 8'h3C;
    repeat (3) tick();
    axi_read(4'h0, 32'h0000_003C, "rd_sw");
    axi_write(4'h0, 32'hFFFF_FFFF, 4'hF, "wr_sw_ro");
    axi_read(4'h0, 32'h0000_003C, "rd_sw_after");
    axi_read(4'h4, 32'h0000_0000, "rd_btn_idle");
    axi_write(4'h4, 32'hFFFF_FFFF, 4'hF, "wr_btn_ro");
    axi_read(4'hC, 32'h0000_0034, "rd_led_kept");

    // button edge latch and irq
    axi_write(4'hC, 32'h8000_0000, 4'hF, "wr_irq_en");
    check_val("led_off", {24'd0, led}, 32'd0);
    btn = 5'b00100;
    repeat (4) tick();
    btn = 5'b00000;
    repeat (4) tick();
    check_val("irq_set", {31'd0, irq}, 32'd1);
    axi_read(4'h8, 32'h0000_0004, "rd_edge");
    axi_write(4'h8, 32'h0000_0004, 4'h0, "wr_edge_nostrb");
    axi_read(4'h8, 32'h0000_0004, "rd_edge_kept");
    check_val("irq_kept", {31'd0, irq}, 32'd1);
    axi_write(4'h8, 32'h0000_0004, 4'hF, "wr_edge_clr");
    check_val("irq_clr", {31'd0, irq}, 32'd0);
    axi_read(4'h8, 32'h0000_0000, "rd_edge_clr");

    // two buttons held: BTN level and both edges visible
    btn = 5'b10001;
    repeat (4) tick();
    axi_read(4'h4, 32'h0000_0011, "rd_btn_held");
    axi_read(4'h8, 32'h0000_0011, "rd_edge_two");
    check_val("irq_two", {31'd0, irq}, 32'd1);
    btn = 5'b00000;
    repeat (3) tick();
    axi_write(4'h8, 32'hFFFF_FFFF, 4'hF, "wr_edge_all");
    check_val("irq_clr_all", {31'd0, irq}, 32'd0);
    axi_read(4'h8, 32'h0000_0000, "rd_edge_none");

    // lone AW waits for W; bvalid held while bready low
    s_axi_awaddr  = 4'hC;
    s_axi_wdata   = 32'h0000_0055;
    s_axi_wstrb   = 4'hF;
    s_axi_awvalid = 1'b1;
    s_axi_wvalid  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_val("lone_aw_awready", {31'd0, s_axi_awready}, 32'd0);
    end
    s_axi_wvalid = 1'b1;
    guard = 0;
    do begin
      tick();
      guard++;
    end while (!s_axi_awready && guard < 20);
    check_val("late_w_awready", {31'd0, s_axi_awready}, 32'd1);
    check_val("late_w_wready",  {31'd0, s_axi_wready},  32'd1);
    tick();
    s_axi_awvalid = 1'b0;
    s_axi_wvalid  = 1'b0;
    check_val("single_pulse", {31'd0, s_axi_awready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      check_val("bvalid_hold", {31'd0, s_axi_bvalid}, 32'd1);
      tick();
    end
    check_val("bvalid_hold_last", {31'd0, s_axi_bvalid}, 32'd1);
    s_axi_bready = 1'b1;
    tick();
    s_axi_bready = 1'b0;
    check_val("bvalid_released", {31'd0, s_axi_bvalid}, 32'd0);
    check_val("led_55", {24'd0, led}, 32'h0000_0055);

    // reset while a read response is pending
    s_axi_araddr  = 4'hC;
    s_axi_arvalid = 1'b1;
    guard = 0;
    do begin
      tick();
      guard++;
    end while (!s_axi_arready && guard < 20);
    tick();
    s_axi_arvalid = 1'b0;
    check_val("pend_rvalid", {31'd0, s_axi_rvalid}, 32'd1);
    check_val("pend_rdata",  s_axi_rdata, 32'h0000_0055);
    tick();
    check_val("pend_rvalid_stable", {31'd0, s_axi_rvalid}, 32'd1);
    check_val("pend_rdata_stable",  s_axi_rdata, 32'h0000_0055);
    reset = 1'b1;
    tick();
    check_val("rst_mid_rvalid", {31'd0, s_axi_rvalid}, 32'd0);
    check_val("rst_mid_rdata",  s_axi_rdata,           32'd0);
    check_val("rst_mid_led",    {24'd0, led},          32'd0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val("no_stale_rvalid", {31'd0, s_axi_rvalid}, 32'd0);
    end
    axi_read(4'hC, 32'h0000_0000, "rd_led_after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
